// File: rtl/fifo_pop_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pop_arbiter_pkg
// Description : Shared constants, FSM state encoding and next-state helper
//               for the FIFO bank read-side arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pop_arbiter_pkg;

  // Bank size is fixed at four FIFOs, addressed by a 2-bit index.
  localparam int NUM_FIFOS = 4;
  localparam int IDX_WIDTH = 2;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_PAUSED = 2'd3
  } state_t;

  // Next FSM state from the current state, whether any FIFO holds data,
  // and the downstream pause input sampled in the same cycle.
  function automatic state_t next_state(state_t cur, logic any_req, logic pause);
    state_t nxt;
    nxt = cur;
    case (cur)
      ST_INIT:   nxt = ST_IDLE;
      ST_IDLE:   if (pause) nxt = ST_PAUSED;
                 else if (any_req) nxt = ST_ACTIVE;
      ST_ACTIVE: if (pause) nxt = ST_PAUSED;
                 else if (!any_req) nxt = ST_IDLE;
      ST_PAUSED: if (!pause) nxt = ST_IDLE;
      default:   nxt = ST_INIT;
    endcase
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_pop_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pop_arbiter_if
// Description : Bundle of the FIFO-bank flags/data, pop strobes, downstream
//               pause and forwarded-word outputs of the pop arbiter.
//               master = arbiter side, slave = FIFO bank / downstream side.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_pop_arbiter_if #(
  parameter int DATA_WIDTH = 4,
  parameter int CNT_WIDTH  = 16
);
  import fifo_pop_arbiter_pkg::*;

  logic [NUM_FIFOS-1:0]            fifo_empty;
  logic [NUM_FIFOS-1:0]            fifo_almost_full;
  logic [NUM_FIFOS*DATA_WIDTH-1:0] fifo_data;
  logic [NUM_FIFOS-1:0]            fifo_rd_en;
  logic                            down_pause;
  logic [DATA_WIDTH-1:0]           data_out;
  logic [IDX_WIDTH-1:0]            dest_out;
  logic                            valid_out;
  logic [CNT_WIDTH-1:0]            word_count;
  logic [1:0]                      state_out;

  modport master (
    input  fifo_empty, fifo_almost_full, fifo_data, down_pause,
    output fifo_rd_en, data_out, dest_out, valid_out, word_count, state_out
  );

  modport slave (
    output fifo_empty, fifo_almost_full, fifo_data, down_pause,
    input  fifo_rd_en, data_out, dest_out, valid_out, word_count, state_out
  );

endinterface
`default_nettype wire

// File: rtl/fifo_pop_arbiter_rr_arbiter4.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pop_arbiter_rr_arbiter4
// Description : Combinational 4-way round-robin arbiter. The search starts at
//               ptr and wraps; returns a one-hot grant, its index and whether
//               any request was present.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_pop_arbiter_rr_arbiter4
  import fifo_pop_arbiter_pkg::*;
(
  input  logic [NUM_FIFOS-1:0] req,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic [NUM_FIFOS-1:0] grant,
  output logic [IDX_WIDTH-1:0] idx,
  output logic                 any
);

  // Scan ptr, ptr+1, ... (2-bit wrap) and take the first requester.
  always_comb begin
    logic [IDX_WIDTH-1:0] w_cand;
    grant  = '0;
    idx    = '0;
    any    = 1'b0;
    w_cand = '0;
    for (int k = 0; k < NUM_FIFOS; k++) begin
      w_cand = ptr + IDX_WIDTH'(k);
      if (!any && req[w_cand]) begin
        any           = 1'b1;
        idx           = w_cand;
        grant[w_cand] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_pop_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pop_arbiter
// Description : Read-side controller for a bank of four fifo8 instances.
//               Pops at most one FIFO per cycle (round-robin, almost_full
//               FIFOs first), captures the popped word one cycle later and
//               forwards it tagged with its source index.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_pop_arbiter
  import fifo_pop_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int NUM_PORTS  = 4,   // fixed at 4 in this revision
  parameter int CNT_WIDTH  = 16
)(
  input  logic               clk,
  input  logic               rst,
  fifo_pop_arbiter_if.master bus
);

  state_t                 r_state;
  logic [IDX_WIDTH-1:0]   r_rr_ptr;
  logic                   r_pending;
  logic [IDX_WIDTH-1:0]   r_pend_idx;
  logic [DATA_WIDTH-1:0]  r_data_out;
  logic [IDX_WIDTH-1:0]   r_dest_out;
  logic                   r_valid_out;
  logic [CNT_WIDTH-1:0]   r_word_count;

  logic [NUM_PORTS-1:0]   w_req;
  logic [NUM_PORTS-1:0]   w_hi;
  logic [NUM_PORTS-1:0]   w_hi_grant;
  logic [NUM_PORTS-1:0]   w_lo_grant;
  logic [IDX_WIDTH-1:0]   w_hi_idx;
  logic [IDX_WIDTH-1:0]   w_lo_idx;
  logic                   w_hi_any;
  logic                   w_lo_any;
  logic [NUM_PORTS-1:0]   w_sel_grant;
  logic [IDX_WIDTH-1:0]   w_sel_idx;
  logic                   w_grant_ok;
  logic [DATA_WIDTH-1:0]  w_words [NUM_PORTS];

  // Split the flat buf_out bus into per-FIFO words.
  generate
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
      assign w_words[i] = bus.fifo_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign w_req = ~bus.fifo_empty;
  assign w_hi  = w_req & bus.fifo_almost_full;

  // Urgent class: non-empty FIFOs that are also near full.
  fifo_pop_arbiter_rr_arbiter4 u_arb_hi (
    .req   (w_hi),
    .ptr   (r_rr_ptr),
    .grant (w_hi_grant),
    .idx   (w_hi_idx),
    .any   (w_hi_any)
  );

  // Normal class: every non-empty FIFO.
  fifo_pop_arbiter_rr_arbiter4 u_arb_lo (
    .req   (w_req),
    .ptr   (r_rr_ptr),
    .grant (w_lo_grant),
    .idx   (w_lo_idx),
    .any   (w_lo_any)
  );

  // Urgent class wins whenever it has a candidate.
  always_comb begin
    w_sel_grant = w_lo_grant;
    w_sel_idx   = w_lo_idx;
    if (w_hi_any) begin
      w_sel_grant = w_hi_grant;
      w_sel_idx   = w_hi_idx;
    end
  end

  // Pause and reset gate the pop immediately; INIT/PAUSED never pop.
  assign w_grant_ok = !rst && !bus.down_pause && w_lo_any &&
                      ((r_state == ST_IDLE) || (r_state == ST_ACTIVE));

  assign bus.fifo_rd_en = w_grant_ok ? w_sel_grant : '0;

  // FSM plus grant bookkeeping: pointer advances past the winner, and the
  // popped index is remembered for capture on the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_INIT;
      r_rr_ptr   <= '0;
      r_pending  <= 1'b0;
      r_pend_idx <= '0;
    end else begin
      r_state <= next_state(r_state, w_lo_any, bus.down_pause);
      if (w_grant_ok) begin
        r_rr_ptr   <= w_sel_idx + IDX_WIDTH'(1);
        r_pending  <= 1'b1;
        r_pend_idx <= w_sel_idx;
      end else begin
        r_pending  <= 1'b0;
      end
    end
  end

  // Capture the word fifo8 presented after the pop edge and forward it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_out   <= '0;
      r_dest_out   <= '0;
      r_valid_out  <= 1'b0;
      r_word_count <= '0;
    end else if (r_pending) begin
      r_data_out   <= w_words[r_pend_idx];
      r_dest_out   <= r_pend_idx;
      r_valid_out  <= 1'b1;
      r_word_count <= r_word_count + CNT_WIDTH'(1);
    end else begin
      r_valid_out  <= 1'b0;
    end
  end

  assign bus.data_out   = r_data_out;
  assign bus.dest_out   = r_dest_out;
  assign bus.valid_out  = r_valid_out;
  assign bus.word_count = r_word_count;
  assign bus.state_out  = r_state;

endmodule
`default_nettype wire

// File: doc/fifo_pop_arbiter.md
Name: fifo_pop_arbiter

Overview:
Read-side controller for a bank of four fifo8 instances; it is the consumer end of their wr_en/rd_en push/pop protocol.
- Watches each FIFO's buf_empty/almost_full flags, issues at most one rd_en per cycle, and captures the popped buf_out word.
- Forwards the word downstream tagged with its source index.
- Arbitration is round-robin, with priority to FIFOs flagging almost_full; a downstream pause input throttles it.

Parameters:
DATA_WIDTH, 4, word width; matches fifo8 DATA_WIDTH.
NUM_PORTS, 4, number of FIFOs drained; fixed at 4 in this revision (2-bit index).
CNT_WIDTH, 16, width of forwarded-word counter.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
fifo_empty  input  NUM_PORTS  buf_empty of each FIFO (bit i = FIFO i)
fifo_almost_full  input  NUM_PORTS  almost_full of each FIFO
fifo_data  input  NUM_PORTS*DATA_WIDTH  buf_out of each FIFO, FIFO i at bits [i*DATA_WIDTH +: DATA_WIDTH]
fifo_rd_en  output  NUM_PORTS  one-hot-or-zero pop strobe to each FIFO
down_pause  input  1  downstream almost_full; blocks new pops
data_out  output  DATA_WIDTH  forwarded word
dest_out  output  2  index of source FIFO of data_out
valid_out  output  1  data_out/dest_out valid this cycle
word_count  output  CNT_WIDTH  total words forwarded since reset, wraps
state_out  output  2  current FSM state, debug

Behaviour:
- Reset (async, rst=1) values:
  - data_out=0, dest_out=0, valid_out=0, word_count=0.
  - rr_ptr=0, pending=0, state=INIT.
  - fifo_rd_en=0 combinationally while rst=1 or state=INIT.
- FSM states, encoded INIT=0, IDLE=1, ACTIVE=2, PAUSED=3:
  - INIT: exactly one cycle after reset release, then goes to IDLE; no pops.
  - IDLE: no request; goes to ACTIVE when any fifo_empty bit is 0 and down_pause=0; goes to PAUSED when down_pause=1.
  - ACTIVE: one grant issued this cycle; stays ACTIVE while requests exist and no pause; goes to IDLE when all empty; goes to PAUSED on down_pause=1.
  - PAUSED: no new grants; goes to IDLE when down_pause=0.
  - The next state is evaluated each cycle from the current inputs.
- Request and grant:
  - req[i] = !fifo_empty[i].
  - hi[i] = req[i] & fifo_almost_full[i].
  - If any hi bit is set, choose round-robin among hi starting at rr_ptr; otherwise round-robin among req starting at rr_ptr.
- fifo_rd_en is combinational: one-hot grant when down_pause=0 and state is not INIT/PAUSED; otherwise 0.
  - Grant decisions in IDLE/ACTIVE use the same-cycle down_pause, so pause blocks pops immediately.
  - At most one bit is set per cycle.
- On a grant to index g: rr_ptr <= g+1 (mod 4); pending <= 1; pend_idx <= g.
- fifo8 updates buf_out and its counter on the same edge as the pop, so in the next cycle fifo_data[pend_idx] holds the word and the empty flags are current. This makes back-to-back pops, including two pops from the same FIFO, legal.
- Capture cycle (pending=1): data_out <= fifo_data[pend_idx]; dest_out <= pend_idx; valid_out <= 1; word_count <= word_count+1.
  - Otherwise valid_out <= 0, and data_out/dest_out hold their values.
- Latency: rd_en asserted in cycle N, valid_out=1 in cycle N+2. Sustained throughput is 1 word/cycle.
- down_pause: at most 2 words (pending plus output register) are delivered after pause rises. The downstream threshold must reserve 2 slots.
- Simultaneous: grant and capture occur in the same cycle in the pipelined steady state. A pause arriving while pending=1 still completes that capture.
- Reset mid-operation: the in-flight word is dropped; no valid_out is produced for it.
- word_count wraps from 2^CNT_WIDTH-1 to 0.

Decomposition:
- Shared package/header (fifo_pkg.vh): FSM state encodings (ST_INIT, ST_IDLE, ST_ACTIVE, ST_PAUSED), NUM_PORTS, index width.
- Sub-module rr_arbiter4: combinational 4-way round-robin grant given req[3:0] and ptr[1:0] → one-hot grant plus index. Instantiated twice (hi class and normal class); the outer logic selects the class.

Test Plan:
- Reset with FIFOs 0-3 preloaded with {1,2},{3},{},{4} and down_pause=0 → after INIT, rd_en order 0,1,3,0; valid_out words 1,3,4,2 with dest 0,1,3,0 at cycles rd+2; word_count=4; then IDLE.
- FIFO 2 almost_full=1 with FIFOs 0 and 2 non-empty, rr_ptr=0 → FIFO 2 granted first, then 0.
- Single FIFO 1 holding 3 words (A,B,C) → rd_en[1] asserted 3 consecutive cycles; valid_out high 3 consecutive cycles with A,B,C; no 4th pop once empty=1.
- down_pause=1 rises while streaming → rd_en=0 in the same cycle; at most 2 further valid_out pulses; state=PAUSED; resumes in order on release.
- Assert rst one cycle after a grant → no valid_out for that word, all outputs 0, state=INIT.
- Preset 65535 forwarded words, or force CNT_WIDTH=4 and send 17 words → word_count wraps to 0 (CNT_WIDTH=4 case ends at 1).
